multi_attempt_lock: RTL and testbench
=====================================

// Module: multi_attempt_lock
// PURPOSE
//  Parametrised successor to the single-code digital lock. Accepts a SEQ_LEN-digit code from
//  KEY_COUNT pushbuttons, unlocks on match, counts failed attempts and enters a timed lockout
//  after MAX_ATTEMPTS misses. Aborts a partial entry after TIMEOUT_SECONDS of inactivity.
//  Supports re-programming the code while unlocked. Sits between board pushbuttons and the
//  hex display decoders.
// PARAMETERS
//  SEQ_LEN          4         digits per code (>=1)
//  KEY_COUNT        4         pushbuttons; digit width DW = $clog2(KEY_COUNT) (KEY_COUNT>=2)
//  CLOCK_FREQUENCY  50000000  clock cycles per second (one-second tick period)
//  TIMEOUT_SECONDS  10        inactivity limit during ENTER/PROGRAM (>=1)
//  MAX_ATTEMPTS     3         consecutive misses before lockout (>=1)
//  LOCKOUT_SECONDS  30        lockout duration (>=1)
//  DEFAULT_CODE     0         SEQ_LEN*DW bits, digit 0 in LSBs; code loaded at reset
// PORTS
//  clock         in   1                    system clock
//  reset         in   1                    synchronous, active-low reset
//  key           in   KEY_COUNT            raw pushbuttons, active-low, asynchronous
//  program       in   1                    switch: 1 = next press while unlocked enters PROGRAM
//  lock          out  1                    1 = locked (all states except UNLOCKED/PROGRAM)
//  lockout       out  1                    1 while in LOCKOUT
//  timeoutError  out  1                    one-cycle pulse when an entry is aborted by timeout
//  attemptsLeft  out  $clog2(MAX_ATTEMPTS+1)  MAX_ATTEMPTS minus consecutive misses
//  bitNumber     out  $clog2(SEQ_LEN+1)    digits captured in current entry
//  lastDigit     out  DW                   most recent accepted digit (for hex0)
//  state         out  3                    state encoding, debug
// BEHAVIOUR
//  Reset (reset==0 at clock edge, wins over everything): state=LOCKED, lock=1, lockout=0,
//   timeoutError=0, attemptsLeft=MAX_ATTEMPTS, bitNumber=0, lastDigit=0, code=DEFAULT_CODE,
//   synchronisers cleared to "released". Reset mid-entry/lockout/program discards all progress.
//  Press detection: key passes through a 2-flop synchroniser. A press event is a one-cycle pulse
//   when the synchronised vector goes from all-released to exactly one button pressed. Digit =
//   index of that button. Multiple buttons, or a second button added while one is held, -> no event.
//  States: LOCKED, ENTER, CHECK, UNLOCKED, PROGRAM, LOCKOUT.
//   LOCKED:   press -> store digit 0, bitNumber=1, go ENTER (SEQ_LEN==1: go CHECK).
//   ENTER:    press -> store digit[bitNumber], bitNumber++. On the last digit go CHECK.
//   CHECK:    1 cycle. Compare entry vs code.
//             Match -> UNLOCKED, attemptsLeft=MAX_ATTEMPTS.
//             Miss  -> attemptsLeft--. If it reaches 0 -> LOCKOUT, else -> LOCKED.
//             bitNumber=0 either way. lock falls on the edge that enters UNLOCKED, i.e. 2
//             cycles after the final press event.
//   UNLOCKED: press with program==0 -> LOCKED.
//             press with program==1 -> PROGRAM, with that press stored as new digit 0.
//   PROGRAM:  presses fill a shadow register. After SEQ_LEN digits: code <= shadow, go LOCKED.
//             On timeout: shadow discarded, code unchanged, return UNLOCKED.
//   LOCKOUT:  presses ignored. After LOCKOUT_SECONDS of ticks -> LOCKED,
//             attemptsLeft=MAX_ATTEMPTS.
//  Timer: a single cycle prescaler (0..CLOCK_FREQUENCY-1) generates a 1-s tick. A seconds
//   down-counter is loaded and the prescaler cleared on entry to ENTER/PROGRAM/LOCKOUT and on
//   every accepted press. Timeout when the counter reaches 0 in ENTER/PROGRAM:
//   timeoutError=1 for 1 cycle, bitNumber=0.
//   ENTER timeout -> LOCKED; it is not counted as an attempt.
//   A press and an expiry in the same cycle: the press wins and the timer reloads.
//  Presses arriving in CHECK are ignored. lastDigit updates on every accepted press.
//  Arithmetic: attemptsLeft never wraps below 0. bitNumber is bounded by SEQ_LEN.
// STRUCTURE
//  Package lock_pkg: state enum localparams (LOCKED=0, ENTER=1, CHECK=2, UNLOCKED=3,
//   PROGRAM=4, LOCKOUT=5), plus a DW/width helper function.
//  Sub-module key_press_detector: synchroniser plus one-hot validation and edge detection.
//   Outputs pressEvent and pressDigit.
//  FSM, timer and code storage stay in this module.
//  7-segment decoding is external (existing hex decoder).
// TESTING (CLOCK_FREQUENCY=10, TIMEOUT_SECONDS=3, MAX_ATTEMPTS=3, LOCKOUT_SECONDS=5,
//   SEQ_LEN=4, DEFAULT_CODE={3,2,1,0})
//  1 Press 0,1,2,3 -> lock=0 exactly 2 cycles after the 4th pressEvent; attemptsLeft=3.
//  2 Three wrong codes (0,0,0,0) -> attemptsLeft 2,1, then lockout=1.
//    Presses are ignored for 50 cycles, then LOCKED with attemptsLeft=3.
//  3 Press 0,1 then idle 30 cycles -> timeoutError pulse, bitNumber=0, attemptsLeft unchanged.
//  4 Unlocked with program=1: press 3,3,1,0 -> LOCKED.
//    Old code is then rejected; entering 3,3,1,0 unlocks.
//  5 Hold keys 0 and 1 together -> no digit. Assert reset=0 mid-entry -> all outputs at
//    reset values next cycle.
//  6 Press coinciding with the expiry cycle -> no timeoutError; entry continues.

Source files
------------

// File: rtl/lock_pkg.sv
// lock_pkg: state encoding and width helper shared by the multi-attempt lock.
package lock_pkg;
  typedef enum logic [2:0] {
    LOCKED   = 3'd0,
    ENTER    = 3'd1,
    CHECK    = 3'd2,
    UNLOCKED = 3'd3,
    PROGRAM  = 3'd4,
    LOCKOUT  = 3'd5
  } state_e;
  function automatic int width_of(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/key_press_detector.sv
// key_press_detector: synchronises active-low keys and pulses once per clean single-button press.
module key_press_detector #(
  parameter int KEY_COUNT = 4,
  parameter int DW        = 2
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [KEY_COUNT-1:0] key_i,
  output logic                 press_event_o,
  output logic [DW-1:0]        press_digit_o
);
  logic [KEY_COUNT-1:0] s1_q, s2_q, prev_q, held;
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      s1_q   <= '1;
      s2_q   <= '1;
      prev_q <= '1;
    end else begin
      s1_q   <= key_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end
  assign held = ~s2_q;
  // fires only on the step from all-released to exactly one button down
  assign press_event_o = &prev_q && held != '0 && (held & (held - 1'b1)) == '0;
  always_comb begin
    press_digit_o = '0;
    for (int i = 0; i < KEY_COUNT; i++)
      if (held[i]) press_digit_o = DW'(i);
  end
endmodule

// File: rtl/multi_attempt_lock.sv
// multi_attempt_lock: code lock with attempt counting, timed lockout, entry timeout
// and re-programmable code.
module multi_attempt_lock import lock_pkg::*; #(
  parameter int SEQ_LEN         = 4,
  parameter int KEY_COUNT       = 4,
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int TIMEOUT_SECONDS = 10,
  parameter int MAX_ATTEMPTS    = 3,
  parameter int LOCKOUT_SECONDS = 30,
  parameter logic [SEQ_LEN*width_of(KEY_COUNT)-1:0] DEFAULT_CODE = '0
) (
  input  logic                                 clock_i,
  input  logic                                 reset_i,
  input  logic [KEY_COUNT-1:0]                 key_i,
  input  logic                                 program_i,
  output logic                                 lock_o,
  output logic                                 lockout_o,
  output logic                                 timeout_error_o,
  output logic [width_of(MAX_ATTEMPTS+1)-1:0]  attempts_left_o,
  output logic [width_of(SEQ_LEN+1)-1:0]       bit_number_o,
  output logic [width_of(KEY_COUNT)-1:0]       last_digit_o,
  output logic [2:0]                           state_o
);
  localparam int DW = width_of(KEY_COUNT);
  localparam int AW = width_of(MAX_ATTEMPTS + 1);
  localparam int BW = width_of(SEQ_LEN + 1);
  localparam int CW = SEQ_LEN * DW;
  localparam int SW = width_of((TIMEOUT_SECONDS > LOCKOUT_SECONDS ? TIMEOUT_SECONDS : LOCKOUT_SECONDS) + 1);
  localparam int PW = width_of(CLOCK_FREQUENCY);
  state_e state_q, state_d;
  logic [BW-1:0] bit_q, bit_d, idx;
  logic [AW-1:0] att_q, att_d;
  logic [CW-1:0] buf_q, buf_d, code_q, code_d, wbuf;
  logic [DW-1:0] last_q, last_d, press_digit;
  logic [PW-1:0] pre_q;
  logic [SW-1:0] secs_q;
  logic terr_q, terr_d, press_event, accept, done, tick, expire, reload;
  key_press_detector #(.KEY_COUNT(KEY_COUNT), .DW(DW)) u_kpd (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .key_i         (key_i),
    .press_event_o (press_event),
    .press_digit_o (press_digit)
  );
  assign tick   = pre_q == PW'(CLOCK_FREQUENCY - 1);
  assign expire = tick && secs_q <= SW'(1);
  assign accept = press_event && state_q != CHECK && state_q != LOCKOUT;
  // ENTER and PROGRAM share one capture buffer; the PROGRAM copy is the shadow code
  always_comb begin
    idx  = (state_q == LOCKED || state_q == UNLOCKED) ? '0 : bit_q;
    done = idx + 1'b1 == BW'(SEQ_LEN);
    wbuf = buf_q;
    for (int i = 0; i < SEQ_LEN; i++)
      if (BW'(i) == idx) wbuf[i*DW +: DW] = press_digit;
  end
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    att_d   = att_q;
    buf_d   = buf_q;
    code_d  = code_q;
    terr_d  = 1'b0;
    last_d  = accept ? press_digit : last_q;
    case (state_q)
      LOCKED, ENTER:
        if (accept) begin
          buf_d   = wbuf;
          bit_d   = idx + 1'b1;
          state_d = done ? CHECK : ENTER;
        end else if (state_q == ENTER && expire) begin
          bit_d   = '0;
          terr_d  = 1'b1;
          state_d = LOCKED;
        end
      CHECK: begin
        bit_d = '0;
        if (buf_q == code_q) begin
          att_d   = AW'(MAX_ATTEMPTS);
          state_d = UNLOCKED;
        end else begin
          att_d   = att_q - AW'(att_q != '0);
          state_d = att_q <= AW'(1) ? LOCKOUT : LOCKED;
        end
      end
      UNLOCKED, PROGRAM:
        if (accept && (program_i || state_q == PROGRAM)) begin
          buf_d   = wbuf;
          bit_d   = done ? '0 : idx + 1'b1;
          code_d  = done ? wbuf : code_q;
          state_d = done ? LOCKED : PROGRAM;
        end else if (accept) begin
          state_d = LOCKED;
        end else if (state_q == PROGRAM && expire) begin
          bit_d   = '0;
          terr_d  = 1'b1;
          state_d = UNLOCKED;
        end
      LOCKOUT:
        if (expire) begin
          att_d   = AW'(MAX_ATTEMPTS);
          state_d = LOCKED;
        end
      default: state_d = LOCKED;
    endcase
    reload = accept || (state_d != state_q && (state_d == ENTER || state_d == PROGRAM || state_d == LOCKOUT));
  end
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q <= LOCKED;
      bit_q   <= '0;
      att_q   <= AW'(MAX_ATTEMPTS);
      buf_q   <= '0;
      code_q  <= DEFAULT_CODE;
      last_q  <= '0;
      terr_q  <= 1'b0;
      pre_q   <= '0;
      secs_q  <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      att_q   <= att_d;
      buf_q   <= buf_d;
      code_q  <= code_d;
      last_q  <= last_d;
      terr_q  <= terr_d;
      pre_q   <= (reload || tick) ? '0 : pre_q + 1'b1;
      secs_q  <= reload ? (state_d == LOCKOUT ? SW'(LOCKOUT_SECONDS) : SW'(TIMEOUT_SECONDS))
                        : secs_q - SW'(tick && secs_q != '0);
    end
  end
  assign lock_o          = !(state_q == UNLOCKED || state_q == PROGRAM);
  assign lockout_o       = state_q == LOCKOUT;
  assign timeout_error_o = terr_q;
  assign attempts_left_o = att_q;
  assign bit_number_o    = bit_q;
  assign last_digit_o    = last_q;
  assign state_o         = state_q;
endmodule

// File: tb/tb_multi_attempt_lock.sv
// tb_multi_attempt_lock: table-driven press/expect vectors plus hand-timed lockout,
// timeout and reset sequences.
module tb_multi_attempt_lock;
  logic clk = 1'b0, rst_n = 1'b0, prog = 1'b0;
  logic [3:0] key = '1;
  logic lock, lockout, terr;
  logic [1:0] att, ld;
  logic [2:0] bn, st;
  int cmp = 0, err = 0;
  typedef struct {
    int digit;
    int prog;
    int st;
    int lk;
    int att;
    int bn;
  } vec_t;
  vec_t tbl[17];
  multi_attempt_lock #(
    .SEQ_LEN(4), .KEY_COUNT(4), .CLOCK_FREQUENCY(10), .TIMEOUT_SECONDS(3),
    .MAX_ATTEMPTS(3), .LOCKOUT_SECONDS(5), .DEFAULT_CODE(8'hE4)
  ) dut (
    .clock_i(clk), .reset_i(rst_n), .key_i(key), .program_i(prog),
    .lock_o(lock), .lockout_o(lockout), .timeout_error_o(terr),
    .attempts_left_o(att), .bit_number_o(bn), .last_digit_o(ld), .state_o(st)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    cmp++;
    if (act != exp) begin
      err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  // ends at the falling edge just after the rising edge that accepts the press
  task automatic press(input int d);
    logic [3:0] k;
    repeat (3) @(negedge clk);
    k = '1;
    k[d] = 1'b0;
    key = k;
    repeat (3) @(negedge clk);
    key = '1;
  endtask
  task automatic check_reset(input string tag);
    chk({tag, " state"}, st, 0);
    chk({tag, " lock"}, lock, 1);
    chk({tag, " lockout"}, lockout, 0);
    chk({tag, " timeoutError"}, terr, 0);
    chk({tag, " attemptsLeft"}, att, 3);
    chk({tag, " bitNumber"}, bn, 0);
    chk({tag, " lastDigit"}, ld, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    tbl[0]  = '{0, 0, 1, 1, 3, 1};
    tbl[1]  = '{1, 0, 1, 1, 3, 2};
    tbl[2]  = '{2, 0, 1, 1, 3, 3};
    tbl[3]  = '{3, 0, 3, 0, 3, 0};
    tbl[4]  = '{3, 1, 4, 0, 3, 1};
    tbl[5]  = '{3, 1, 4, 0, 3, 2};
    tbl[6]  = '{1, 1, 4, 0, 3, 3};
    tbl[7]  = '{0, 1, 0, 1, 3, 0};
    tbl[8]  = '{0, 0, 1, 1, 3, 1};
    tbl[9]  = '{1, 0, 1, 1, 3, 2};
    tbl[10] = '{2, 0, 1, 1, 3, 3};
    tbl[11] = '{3, 0, 0, 1, 2, 0};
    tbl[12] = '{3, 0, 1, 1, 2, 1};
    tbl[13] = '{3, 0, 1, 1, 2, 2};
    tbl[14] = '{1, 0, 1, 1, 2, 3};
    tbl[15] = '{0, 0, 3, 0, 3, 0};
    tbl[16] = '{2, 0, 0, 1, 3, 0};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("reset");
    press(0);
    press(1);
    press(2);
    press(3);
    chk("t1 check state", st, 2);
    chk("t1 lock during check", lock, 1);
    @(negedge clk);
    chk("t1 unlock lock", lock, 0);
    chk("t1 unlock state", st, 3);
    chk("t1 attempts", att, 3);
    press(1);
    @(negedge clk);
    chk("t1 relock state", st, 0);
    for (int i = 0; i < 17; i++) begin
      prog = tbl[i].prog[0];
      press(tbl[i].digit);
      @(negedge clk);
      chk($sformatf("vec%0d state", i), st, tbl[i].st);
      chk($sformatf("vec%0d lock", i), lock, tbl[i].lk);
      chk($sformatf("vec%0d attempts", i), att, tbl[i].att);
      chk($sformatf("vec%0d bitNumber", i), bn, tbl[i].bn);
      chk($sformatf("vec%0d lastDigit", i), ld, tbl[i].digit);
    end
    prog = 1'b0;
    for (int k = 0; k < 3; k++) begin
      repeat (4) press(0);
      @(negedge clk);
      chk($sformatf("t2 miss%0d attempts", k), att, 2 - k);
      chk($sformatf("t2 miss%0d lockout", k), lockout, k == 2 ? 1 : 0);
    end
    press(2);
    chk("t2 ignored press lockout", lockout, 1);
    chk("t2 ignored press lastDigit", ld, 0);
    chk("t2 ignored press bitNumber", bn, 0);
    repeat (43) @(negedge clk);
    chk("t2 lockout at 50 cycles", lockout, 1);
    @(negedge clk);
    chk("t2 lockout released", lockout, 0);
    chk("t2 release state", st, 0);
    chk("t2 release attempts", att, 3);
    press(0);
    press(1);
    repeat (29) @(negedge clk);
    chk("t3 no early timeout", terr, 0);
    @(negedge clk);
    chk("t3 timeout pulse", terr, 1);
    chk("t3 bitNumber", bn, 0);
    chk("t3 state", st, 0);
    chk("t3 attempts", att, 3);
    @(negedge clk);
    chk("t3 pulse one cycle", terr, 0);
    press(0);
    repeat (24) @(negedge clk);
    press(1);
    chk("t6 no timeout", terr, 0);
    chk("t6 bitNumber", bn, 2);
    chk("t6 state", st, 1);
    @(negedge clk);
    chk("t6 still no timeout", terr, 0);
    key = 4'b1100;
    repeat (6) @(negedge clk);
    chk("t5 two keys bitNumber", bn, 2);
    chk("t5 two keys lastDigit", ld, 1);
    key = '1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("t5 mid-entry reset");
    rst_n = 1'b1;
    press(0);
    press(1);
    press(2);
    press(3);
    @(negedge clk);
    chk("t5 default code restored", lock, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
